// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time burst beats into a
// downstream FIFO write port, releasing on end-of-burst or a beat-count limit.
module fifo_wr_arbiter #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_last,
    input  logic [NREQ-1:0][BITS-1:0]     req_data,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0]               req_enable,
    output logic                          wr_en,
    output logic [BITS-1:0]               wr_data,
    input  logic                          wr_full,
    output logic                          grant_valid,
    output logic [$clog2(NREQ)-1:0]       grant_id
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]  cand;
    logic             found;
    logic [IDW-1:0]   pick;
    int unsigned      idx;

    // First enabled, valid requester after the previous grant holder, circularly.
    always_comb begin
        cand  = req_valid & req_enable;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_q) + i) % NREQ;
            if (!found && cand[IDW'(idx)]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = req_data[grant_q];

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Port is quiet while reset is asserted so an abandoned burst emits nothing.
                req_ready[grant_q] = !wr_full && !wr_rst;
                wr_en              = req_valid[grant_q] && !wr_full && !wr_rst;
                if (wr_en) begin
                    cnt_d = cnt_q + CW'(1);
                    if (req_last[grant_q] || (cnt_d == CW'(MAX_BURST))) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid = (state_q == LOCKED);
    assign grant_id    = (state_q == LOCKED) ? grant_q : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter BITS, default 32: width of each data beat, equal to the write-port width of the downstream FIFO.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..16.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant before forced re-arbitration, at least 1.
REQ-004 wr_clk  input  1  single clock for the whole block.
REQ-005 wr_rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_last  input  NREQ  per-requester end-of-burst marker, qualified by req_valid.
REQ-008 req_data  input  NREQ x BITS  per-requester beat data.
REQ-009 req_ready  output  NREQ  per-requester beat accepted this cycle when high with req_valid.
REQ-010 req_enable  input  NREQ  per-requester arbitration mask; 0 excludes that requester from new grants.
REQ-011 wr_en  output  1  write strobe to the FIFO.
REQ-012 wr_data  output  BITS  write data to the FIFO.
REQ-013 wr_full  input  1  FIFO full flag.
REQ-014 grant_valid  output  1  a requester currently holds the grant.
REQ-015 grant_id  output  clog2(NREQ)  index of the current grant holder; 0 when grant_valid=0.

Function
REQ-016 The FSM SHALL have two states: IDLE (no grant) and LOCKED (one requester owns the write port).
REQ-017 In IDLE, the candidate set SHALL be req_valid AND req_enable.
REQ-018 If the candidate set is non-empty, the block SHALL pick the first candidate searching circularly from last_grant+1, register it as grant_id, clear the beat counter and move to LOCKED on the next edge.
REQ-019 In IDLE, wr_en and all req_ready bits SHALL be 0, so the arbitration cycle is one bubble cycle.
REQ-020 In LOCKED with holder g: req_ready[g] = !wr_full, wr_en = req_valid[g] && !wr_full, and wr_data = req_data[g], all combinational.
REQ-021 In LOCKED, req_ready SHALL be 0 for every requester other than g.
REQ-022 A beat is accepted when wr_en=1, and each accepted beat SHALL increment the beat counter, sized clog2(MAX_BURST+1) bits.
REQ-023 The block SHALL release the grant and return to IDLE on the edge after an accepted beat that has req_last[g]=1, or that brings the beat counter to MAX_BURST, whichever comes first.
REQ-024 On release, last_grant SHALL take the value g.
REQ-025 While wr_full=1 in LOCKED, the grant SHALL be held, the beat counter SHALL not advance and no beat SHALL be accepted; there is no timeout.
REQ-026 req_valid[g] dropping in LOCKED SHALL not release the grant; the holder keeps the port until last or MAX_BURST.
REQ-027 Clearing req_enable[g] mid-burst SHALL not abort the burst; it affects only later arbitration.
REQ-028 wr_en SHALL never be 1 while wr_full=1, so no beat is lost or duplicated.
REQ-029 Output ordering SHALL equal per-requester input order, and a burst SHALL never interleave with another requester.
REQ-030 Fairness: with all requesters continuously valid and enabled, grants SHALL rotate 0,1,...,NREQ-1,0,...

Reset
REQ-031 While wr_rst=1 at a wr_clk edge, the block SHALL force: state IDLE, beat counter 0, last_grant NREQ-1 (requester 0 has first priority), and grant_id 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no further wr_en.
REQ-033 During and after reset until the first grant: wr_en=0, req_ready=0, grant_valid=0, grant_id=0; wr_data is a don't-care while wr_en=0.

Verification
REQ-034 Reset, then req_valid=4'b1111 and req_last=4'b1111 held, enable=4'b1111, wr_full=0 -> single-beat grants in order 0,1,2,3,0, one beat every 2 cycles.
REQ-035 Requester 2 sends a 3-beat burst (last on beat 3) while requester 1 is valid -> 3 consecutive wr_en carrying requester 2's data, then a bubble, then requester 1 is granted (circular search from 3 wraps 3,0,1).
REQ-036 MAX_BURST=4 and requester 0 sends 6 beats with no last -> release after beat 4, re-arbitration, then remaining beats resume when requester 0 is next granted.
REQ-037 wr_full=1 for 5 cycles mid-burst -> wr_en=0 and req_ready=0 during the stall, counter frozen, burst completes intact afterwards with no beat lost or duplicated.
REQ-038 req_enable=4'b0101 with all requesters valid -> only requesters 0 and 2 are granted, alternating; clearing enable bit 0 mid-burst lets the current burst finish.
REQ-039 wr_rst pulsed for 1 cycle during a LOCKED burst -> the next cycle shows grant_valid=0 and wr_en=0, and the first new grant goes to the lowest-index valid enabled requester.
